// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and dmem_responder.
// master = requester (core side), slave = responder.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  resp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
               req_unsigned_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
               req_unsigned_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Optional macro DMEM_MISALIGN_ERR_EN: flag misaligned half/word accesses as errors.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave bus
);
    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          WIDX_W   = ADDR_WIDTH - 2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [31:0]           mem_q [DEPTH_WORDS];
    logic [WIDX_W-1:0]     word_idx_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic                  oor_s;
    logic                  misalign_s;
    logic                  err_s;
    logic [31:0]           rd_word_s;
    logic                  mem_we_s;
    logic [3:0]            mem_be_s;
    logic [31:0]           mem_wdata_s;

    // Byte-lane enables; half/word lanes ignore the low address bits they do not use.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lo;
            2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   store_lanes = {4{wd[7:0]}};
            2'b01:   store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   load_extract = word;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    assign word_idx_s = addr_q[ADDR_WIDTH-1:2];
    assign mem_idx_s  = word_idx_s[IDX_W-1:0];
    assign oor_s      = (word_idx_s >= WIDX_W'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign_s = ((size_q == 2'b01) && addr_q[0]) ||
                        ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif
    assign err_s       = oor_s || (size_q == 2'b11) || misalign_s;
    assign rd_word_s   = mem_q[mem_idx_s];
    assign mem_be_s    = lane_mask(size_q, addr_q[1:0]);
    assign mem_wdata_s = store_lanes(size_q, wdata_q);

    // Next-state, request latch, access commit and response registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i && req_ready_q) begin
                    we_d    = bus.req_we_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    size_d  = bus.req_size_i;
                    uns_d   = bus.req_unsigned_i;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    err_d    = err_s;
                    rdata_d  = (err_s || we_q) ? 32'h0000_0000
                                               : load_extract(rd_word_s, size_q, addr_q[1:0], uns_q);
                    mem_we_s = we_q && !err_s;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // Control and response registers; reset aborts any in-flight access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be_s[i]) begin
                    mem_q[mem_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = DATA_WIDTH'(rdata_q);
    assign bus.resp_err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, random backpressure.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   bp_mode = 0;           // 0 random ready, 1 hold low, 2 hold high

    logic [7:0]  mdl [0:4*DEPTH-1];
    logic [32:0] exp_q [$];
    int          acc_q [$];

    dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    // Reference model: byte-addressed memory, architectural access rules.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output logic e, output logic [31:0] d);
        int unsigned nb;
        int unsigned ea;
        logic [31:0] v;
        e = 1'b0;
        d = 32'h0;
        if ((addr >> 2) >= DEPTH) e = 1'b1;
        if (sz == 2'b11) e = 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
        if (sz == 2'b01 && addr[0]) e = 1'b1;
        if (sz == 2'b10 && addr[1:0] != 2'b00) e = 1'b1;
`endif
        if (e) return;
        nb = 1 << sz;
        ea = addr & ~(nb - 1);
        if (we) begin
            for (int i = 0; i < nb; i++) mdl[ea + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(mdl[ea + i]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            d = v;
        end
    endtask

    task automatic scramble();
        bus.req_addr_i     = $urandom;
        bus.req_wdata_i    = $urandom;
        bus.req_we_i       = 1'($urandom_range(0, 1));
        bus.req_size_i     = 2'($urandom_range(0, 3));
        bus.req_unsigned_i = 1'($urandom_range(0, 1));
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns);
        logic        e;
        logic [31:0] d;
        int          n;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wd;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready_o && n < 200);
        if (!bus.req_ready_o) begin
            errors++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high addr=%0h", addr);
            bus.req_valid_i = 1'b0;
            return;
        end
        chk("one_outstanding", 64'(exp_q.size()), 64'd0);
        model(we, addr, wd, sz, uns, e, d);
        exp_q.push_back({e, d});
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending responses", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Consumer ready: random, forced low, or forced high.
    initial begin
        bus.resp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       bus.resp_ready_i = 1'b0;
                2:       bus.resp_ready_i = 1'b1;
                default: bus.resp_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare every presented response against the scoreboard head.
    initial begin
        logic        prev_valid;
        logic        hs_prev;
        logic [32:0] head;
        prev_valid = 1'b0;
        hs_prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                hs_prev    = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("idle_after_hs_ready", 64'(bus.req_ready_o), 64'd1);
                    chk("idle_after_hs_valid", 64'(bus.resp_valid_o), 64'd0);
                end
                hs_prev = 1'b0;
                if (bus.resp_valid_o) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_resp actual=valid required=no_response");
                    end else begin
                        head = exp_q[0];
                        chk("resp_rdata", 64'(bus.resp_rdata_o), 64'(head[31:0]));
                        chk("resp_err", 64'(bus.resp_err_o), 64'(head[32]));
                        chk("ready_low_in_resp", 64'(bus.req_ready_o), 64'd0);
                        if (!prev_valid && acc_q.size() != 0) begin
                            chk("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
                        end
                        if (bus.resp_ready_i) begin
                            void'(exp_q.pop_front());
                            hs_prev = 1'b1;
                        end
                    end
                end
                prev_valid = bus.resp_valid_o;
            end
        end
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_rdata", 64'(bus.resp_rdata_o), 64'd0);
        chk("rst_err", 64'(bus.resp_err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known contents for the working window 0x00..0x7F.
        for (int i = 0; i < 32; i++) issue(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0);

        // Word store/load
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        // Byte store, signed/unsigned/word reads
        issue(1'b1, 32'h11, 32'h0000_0080, 2'b00, 1'b0);
        issue(1'b0, 32'h11, 32'h0, 2'b00, 1'b0);
        issue(1'b0, 32'h11, 32'h0, 2'b00, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        // Half store and back-to-back loads with valid held
        issue(1'b1, 32'h22, 32'h0000_8001, 2'b01, 1'b0);
        issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
        issue(1'b0, 32'h22, 32'h0, 2'b01, 1'b1);
        drain();

        // Response backpressure
        bp_mode = 1;
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        n = 0;
        while (!bus.resp_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_seen", 64'(bus.resp_valid_o), 64'd1);
        repeat (5) @(negedge clk);
        chk("bp_still_valid", 64'(bus.resp_valid_o), 64'd1);
        bp_mode = 2;
        drain();
        bp_mode = 0;

        // Error cases
        issue(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
        issue(1'b1, 32'h13, 32'hCAFE_F00D, 2'b10, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        issue(1'b0, 32'h23, 32'h0, 2'b01, 1'b0);
        drain();

        // Reset during BUSY aborts the store
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b1;
        bus.req_addr_i     = 32'h40;
        bus.req_wdata_i    = 32'h1234_5678;
        bus.req_size_i     = 2'b10;
        bus.req_unsigned_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready_o && n < 50);
        chk("abort_accepted", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("abort_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
        drain();

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            int unsigned sel;
            logic [31:0] a;
            logic [1:0]  s;
            sel = $urandom_range(0, 15);
            a   = (sel == 0) ? (32'h1000 + 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 127));
            s   = (sel == 1) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), a, $urandom, s, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
